uc_jogo_principal_multiacao: RTL and testbench
==============================================

Name: uc_jogo_principal_multiacao

Overview:
- Parametrised successor of the main-game control unit. Highest-level Moore FSM of the game.
- Registers the player move and starts/stops asteroid+shot movement.
- Dispatches one of NUM_ACOES action sub-units (shot, special, ...), each with its own internal cooldown counter, replacing the external per-action interval counters.
- Handshakes each dispatch with a done signal and a timeout. Can restart from game-over without a reset.

Parameters:
- NUM_ACOES, 2, number of action channels; index 0 has highest priority.
- INTERVALO_CICLOS, 1000, cooldown length in clocks after an action is dispatched.
- SALVA_CICLOS, 2, wait cycles after registering the move (≥1).
- TIMEOUT_CICLOS, 4096, maximum clocks to wait for fim_acao.
- W_CNT, 16, counter width; must hold max(INTERVALO_CICLOS, TIMEOUT_CICLOS).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; forces INICIAL.
- iniciar  in  1  start/restart request.
- vidas  in  1  1 = lives remaining.
- ocorreu_jogada  in  1  move available.
- acoes  in  NUM_ACOES  requested actions; sampled in REGISTRA.
- fim_movimentacao  in  1  movement unit finished.
- fim_acao  in  NUM_ACOES  per-action sub-unit done.
- enable_reg_jogada  out  1  load move register.
- reset_reg_jogada  out  1  clear move register.
- inicia_movimentacao  out  1  movement run enable.
- termina  out  1  request movement to finish.
- inicia_acao  out  NUM_ACOES  one-hot start pulse to a sub-unit.
- reset_maquinas  out  1  reset counters and sub-FSMs (asteroids, shots, lives, machines).
- reset_pontuacao  out  1  clear score.
- pronto  out  1  game over.
- erro_timeout  out  1  one-cycle pulse on action timeout.
- acao_pronta  out  NUM_ACOES  per-action cooldown expired.
- db_estado  out  5  state code.

Behaviour:
- Moore outputs decoded from state only. Exception: acao_pronta[i] = (cooldown[i]==0).
- Reset state and outputs:
  - State INICIAL; all outputs 0; db_estado=0.
  - All cooldowns 0, so acao_pronta = all ones.
  - Latched request and grant registers cleared.
- States (db code) and transitions:
  - INICIAL(0): iniciar → INICIALIZA.
  - INICIALIZA(1): drives reset_reg_jogada, reset_maquinas, reset_pontuacao; clears cooldowns; → ESPERA_JOGADA.
  - ESPERA_JOGADA(2): drives inicia_movimentacao, reset_reg_jogada. Checks in priority order: ~vidas → FIM_JOGO; else ocorreu_jogada → REGISTRA.
  - REGISTRA(3): enable_reg_jogada=1; latches acoes into the request register; → SALVA.
  - SALVA(8): dwells exactly SALVA_CICLOS clocks. On the last clock:
    - ~vidas → FIM_JOGO;
    - else if (req & acao_pronta) ≠ 0 → latch grant = lowest set index, → TERMINA;
    - else → ESPERA_JOGADA.
  - TERMINA(4): termina=1. When fim_movimentacao: ~vidas → FIM_JOGO, else → INICIA_ACAO.
  - INICIA_ACAO(7): inicia_acao[grant]=1 for exactly one clock; cooldown[grant] loads INTERVALO_CICLOS; timeout counter cleared; → ESPERA_ACAO.
  - ESPERA_ACAO(5): fim_acao[grant] → ESPERA_JOGADA. Else when the timeout counter reaches TIMEOUT_CICLOS-1: erro_timeout pulses for one clock on that exit, → ESPERA_JOGADA. fim_acao bits of other channels are ignored.
  - FIM_JOGO(6): pronto=1, reset_reg_jogada=1, reset_maquinas=1. iniciar → INICIALIZA (restart without reset).
  - Any unused encoding → ERRO(31): all outputs 0; stays until reset.
- Cooldowns:
  - Each decrements by 1 per clock while nonzero, in every state except INICIALIZA (cleared) and PAUSADO (frozen).
  - Saturate at 0.
  - A reload in INICIA_ACAO wins over the decrement in the same cycle.
- Simultaneous events:
  - ~vidas has precedence over every other condition in all states that test it.
  - In ESPERA_ACAO, fim_acao wins over timeout when both occur on the same clock.
- Reset mid-operation: asynchronous return to INICIAL, with all registers reset as above.

Optional Feature:
- Macro UC_PAUSA_EN.
- Defined:
  - Adds input port pausa (1 bit) and state PAUSADO(12).
  - In ESPERA_JOGADA, pausa=1 (with vidas=1) takes precedence over ocorreu_jogada and goes → PAUSADO.
  - In PAUSADO: all outputs 0, cooldowns frozen; ~vidas → FIM_JOGO; pausa=0 → ESPERA_JOGADA.
- Undefined: no pausa port; PAUSADO is unreachable and decodes as ERRO.

Test Plan:
- Reset, then iniciar=1 for 1 clock → db_estado 0→1→2; reset_pontuacao high exactly 1 clock; acao_pronta=2'b11.
- Move with acoes=2'b11, then fim_movimentacao and fim_acao[0] → inicia_acao=2'b01 for 1 clock; acao_pronta[0]=0 for INTERVALO_CICLOS clocks, then returns to 1.
- Second move inside action 0's cooldown with acoes=2'b01 → returns from SALVA to ESPERA_JOGADA, no inicia_acao pulse. Same move with acoes=2'b11 → action 1 dispatched instead.
- Hold fim_acao=0 after dispatch → erro_timeout pulses once exactly TIMEOUT_CICLOS clocks after entering ESPERA_ACAO; state returns to 2.
- Drop vidas in TERMINA while fim_movimentacao=1 → FIM_JOGO, pronto=1; then iniciar → state 1 and cooldowns cleared.
- With UC_PAUSA_EN: pausa=1 in ESPERA_JOGADA holds state 12 and freezes acao_pronta countdown; pausa=0 → resumes with the remaining count unchanged.

Source files
------------

// File: rtl/uc_jogo_principal_multiacao.sv
// Main game control unit, multi-action version.
// Top-level Moore FSM: registers the player move, starts/stops movement,
// dispatches one of NUM_ACOES action sub-units (index 0 = highest priority),
// keeps one cooldown counter per action and supervises each dispatch with
// a done handshake plus timeout.
// Optional pause state enabled by macro UC_PAUSA_EN.
module uc_jogo_principal_multiacao #(
  parameter int NUM_ACOES        = 2,
  parameter int INTERVALO_CICLOS = 1000,
  parameter int SALVA_CICLOS     = 2,
  parameter int TIMEOUT_CICLOS   = 4096,
  parameter int W_CNT            = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
`ifdef UC_PAUSA_EN
  input  logic                 pausa,
`endif
  input  logic                 vidas,
  input  logic                 ocorreu_jogada,
  input  logic [NUM_ACOES-1:0] acoes,
  input  logic                 fim_movimentacao,
  input  logic [NUM_ACOES-1:0] fim_acao,
  output logic                 enable_reg_jogada,
  output logic                 reset_reg_jogada,
  output logic                 inicia_movimentacao,
  output logic                 termina,
  output logic [NUM_ACOES-1:0] inicia_acao,
  output logic                 reset_maquinas,
  output logic                 reset_pontuacao,
  output logic                 pronto,
  output logic                 erro_timeout,
  output logic [NUM_ACOES-1:0] acao_pronta,
  output logic [4:0]           db_estado
);

  // state         | meaning
  // INICIAL       | idle after reset, waits for iniciar
  // INICIALIZA    | clears move register, machines, score and cooldowns
  // ESPERA_JOGADA | movement running, waits for a move
  // REGISTRA      | loads move register and latches requested actions
  // SALVA         | dwells SALVA_CICLOS clocks, then arbitrates
  // TERMINA       | asks movement to finish
  // INICIA_ACAO   | one-clock start pulse to the granted sub-unit
  // ESPERA_ACAO   | waits for granted fim_acao or timeout
  // FIM_JOGO      | game over, waits for iniciar to restart
  // PAUSADO       | paused, everything frozen (UC_PAUSA_EN only)
  // ERRO          | illegal encoding trap, leaves only by reset
  typedef enum logic [4:0] {
    INICIAL       = 5'd0,
    INICIALIZA    = 5'd1,
    ESPERA_JOGADA = 5'd2,
    REGISTRA      = 5'd3,
    TERMINA       = 5'd4,
    ESPERA_ACAO   = 5'd5,
    FIM_JOGO      = 5'd6,
    INICIA_ACAO   = 5'd7,
    SALVA         = 5'd8,
    PAUSADO       = 5'd12,
    ERRO          = 5'd31
  } estado_t;

  estado_t estado, proximo;

  logic [W_CNT-1:0]     cooldown [NUM_ACOES];
  logic [W_CNT-1:0]     cnt_salva;
  logic [W_CNT-1:0]     cnt_timeout;
  logic [NUM_ACOES-1:0] req;
  logic [NUM_ACOES-1:0] grant;
  logic [NUM_ACOES-1:0] disponivel;
  logic [NUM_ACOES-1:0] grant_novo;
  logic                 salva_fim;
  logic                 timeout_fim;
  logic                 fim_grant;
`ifdef UC_PAUSA_EN
  logic                 pausa_int;
  assign pausa_int = pausa;
`else
  logic                 pausa_int;
  assign pausa_int = 1'b0;
`endif

  assign salva_fim   = (cnt_salva == '0);
  assign timeout_fim = (cnt_timeout == '0);
  assign fim_grant   = |(fim_acao & grant);
  assign disponivel  = req & acao_pronta;
  assign db_estado   = estado;

  // Lowest-index available request wins the grant.
  always_comb begin
    grant_novo = '0;
    for (int i = NUM_ACOES - 1; i >= 0; i--) begin
      if (disponivel[i]) begin
        grant_novo    = '0;
        grant_novo[i] = 1'b1;
      end
    end
  end

  // Per-action cooldown: cleared on init, reloaded on dispatch, frozen while paused.
  for (genvar g = 0; g < NUM_ACOES; g++) begin : g_cooldown
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        cooldown[g] <= '0;
      else if (estado == INICIALIZA)
        cooldown[g] <= '0;
      else if (estado == INICIA_ACAO && grant[g])
        cooldown[g] <= W_CNT'(INTERVALO_CICLOS);
      else if (estado != PAUSADO && cooldown[g] != '0)
        cooldown[g] <= cooldown[g] - W_CNT'(1);
    end
    assign acao_pronta[g] = (cooldown[g] == '0);
  end

  // Dwell and timeout timers (down-counters, expire at zero), request and grant latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_salva   <= '0;
      cnt_timeout <= '0;
      req         <= '0;
      grant       <= '0;
    end else begin
      if (estado == REGISTRA) begin
        cnt_salva <= W_CNT'(SALVA_CICLOS - 1);
        req       <= acoes;
      end else if (estado == SALVA && !salva_fim) begin
        cnt_salva <= cnt_salva - W_CNT'(1);
      end
      if (estado == SALVA && salva_fim)
        grant <= grant_novo;
      if (estado == INICIA_ACAO)
        cnt_timeout <= W_CNT'(TIMEOUT_CICLOS - 1);
      else if (estado == ESPERA_ACAO && !timeout_fim)
        cnt_timeout <= cnt_timeout - W_CNT'(1);
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo;
  end

  // Next-state and output decode.
  always_comb begin
    proximo             = estado;
    enable_reg_jogada   = 1'b0;
    reset_reg_jogada    = 1'b0;
    inicia_movimentacao = 1'b0;
    termina             = 1'b0;
    inicia_acao         = '0;
    reset_maquinas      = 1'b0;
    reset_pontuacao     = 1'b0;
    pronto              = 1'b0;
    erro_timeout        = 1'b0;
    case (estado)
      INICIAL: if (iniciar) proximo = INICIALIZA;
      INICIALIZA: begin
        reset_reg_jogada = 1'b1;
        reset_maquinas   = 1'b1;
        reset_pontuacao  = 1'b1;
        proximo          = ESPERA_JOGADA;
      end
      ESPERA_JOGADA: begin
        inicia_movimentacao = 1'b1;
        reset_reg_jogada    = 1'b1;
        if (!vidas)              proximo = FIM_JOGO;
        else if (pausa_int)      proximo = PAUSADO;
        else if (ocorreu_jogada) proximo = REGISTRA;
      end
      REGISTRA: begin
        enable_reg_jogada = 1'b1;
        proximo           = SALVA;
      end
      SALVA: begin
        if (salva_fim) begin
          if (!vidas)                proximo = FIM_JOGO;
          else if (disponivel != '0) proximo = TERMINA;
          else                       proximo = ESPERA_JOGADA;
        end
      end
      TERMINA: begin
        termina = 1'b1;
        if (fim_movimentacao) proximo = vidas ? INICIA_ACAO : FIM_JOGO;
      end
      INICIA_ACAO: begin
        inicia_acao = grant;
        proximo     = ESPERA_ACAO;
      end
      ESPERA_ACAO: begin
        if (fim_grant) begin
          proximo = ESPERA_JOGADA;
        end else if (timeout_fim) begin
          erro_timeout = 1'b1;
          proximo      = ESPERA_JOGADA;
        end
      end
      FIM_JOGO: begin
        pronto           = 1'b1;
        reset_reg_jogada = 1'b1;
        reset_maquinas   = 1'b1;
        if (iniciar) proximo = INICIALIZA;
      end
`ifdef UC_PAUSA_EN
      PAUSADO: begin
        if (!vidas)      proximo = FIM_JOGO;
        else if (!pausa) proximo = ESPERA_JOGADA;
      end
`endif
      default: proximo = ERRO;
    endcase
  end

endmodule

// File: tb/tb_uc_jogo_principal_multiacao.sv
// Directed self-checking bench for uc_jogo_principal_multiacao.
// Uses shortened cooldown/timeout lengths; covers the pause state when UC_PAUSA_EN is defined.
module tb_uc_jogo_principal_multiacao;

  localparam int INTERV = 40;
  localparam int TMO    = 24;

  logic       clock, reset, iniciar, vidas, ocorreu_jogada, fim_movimentacao;
  logic [1:0] acoes, fim_acao;
  logic       enable_reg_jogada, reset_reg_jogada, inicia_movimentacao, termina;
  logic       reset_maquinas, reset_pontuacao, pronto, erro_timeout;
  logic [1:0] inicia_acao, acao_pronta;
  logic [4:0] db_estado;
`ifdef UC_PAUSA_EN
  logic       pausa;
`endif

  // Output bundle: [9]enable_reg [8]reset_reg [7]inicia_mov [6]termina [5]reset_maq
  //                [4]reset_pont [3]pronto [2]erro_timeout [1:0]inicia_acao
  logic [9:0] saidas;
  assign saidas = {enable_reg_jogada, reset_reg_jogada, inicia_movimentacao, termina,
                   reset_maquinas, reset_pontuacao, pronto, erro_timeout, inicia_acao};

  int          checks = 0;
  int          errors = 0;
  int unsigned ciclo  = 0;
  int unsigned carga0, carga1;

  uc_jogo_principal_multiacao #(
    .NUM_ACOES(2), .INTERVALO_CICLOS(INTERV), .SALVA_CICLOS(2),
    .TIMEOUT_CICLOS(TMO), .W_CNT(16)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
`ifdef UC_PAUSA_EN
    .pausa(pausa),
`endif
    .vidas(vidas), .ocorreu_jogada(ocorreu_jogada), .acoes(acoes),
    .fim_movimentacao(fim_movimentacao), .fim_acao(fim_acao),
    .enable_reg_jogada(enable_reg_jogada), .reset_reg_jogada(reset_reg_jogada),
    .inicia_movimentacao(inicia_movimentacao), .termina(termina),
    .inicia_acao(inicia_acao), .reset_maquinas(reset_maquinas),
    .reset_pontuacao(reset_pontuacao), .pronto(pronto), .erro_timeout(erro_timeout),
    .acao_pronta(acao_pronta), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    ciclo++;
  endtask

  // Make a move: REGISTRA, two SALVA clocks, then land on the post-SALVA state.
  task automatic jogada(input logic [1:0] a);
    acoes = a; ocorreu_jogada = 1'b1; tick();
    ocorreu_jogada = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 0; vidas = 1; ocorreu_jogada = 0; acoes = 0;
    fim_movimentacao = 0; fim_acao = 0;
`ifdef UC_PAUSA_EN
    pausa = 0;
`endif
    tick(); tick();
    checks++; if (db_estado !== 5'd0) begin errors++; $display("FAIL reset_state got %0d want 0", db_estado); end
    checks++; if (saidas !== 10'b0) begin errors++; $display("FAIL reset_outputs got %b want 0", saidas); end
    checks++; if (acao_pronta !== 2'b11) begin errors++; $display("FAIL reset_pronta got %b want 11", acao_pronta); end
    reset = 1'b0; tick();
    checks++; if (db_estado !== 5'd0) begin errors++; $display("FAIL idle_state got %0d want 0", db_estado); end
  endtask

  task automatic test_start();
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    checks++; if (db_estado !== 5'd1) begin errors++; $display("FAIL start_state got %0d want 1", db_estado); end
    checks++; if (saidas !== 10'b01_0011_0000) begin errors++; $display("FAIL start_outputs got %b want 0100110000", saidas); end
    tick();
    checks++; if (db_estado !== 5'd2) begin errors++; $display("FAIL wait_state got %0d want 2", db_estado); end
    checks++; if (saidas !== 10'b01_1000_0000) begin errors++; $display("FAIL wait_outputs got %b want 0110000000", saidas); end
    checks++; if (acao_pronta !== 2'b11) begin errors++; $display("FAIL start_pronta got %b want 11", acao_pronta); end
  endtask

  task automatic test_dispatch();
    acoes = 2'b11; ocorreu_jogada = 1'b1; tick(); ocorreu_jogada = 1'b0;
    checks++; if (db_estado !== 5'd3 || saidas !== 10'b10_0000_0000) begin errors++; $display("FAIL registra got st=%0d out=%b want st=3 out=1000000000", db_estado, saidas); end
    tick();
    checks++; if (db_estado !== 5'd8) begin errors++; $display("FAIL salva1 got %0d want 8", db_estado); end
    tick();
    checks++; if (db_estado !== 5'd8) begin errors++; $display("FAIL salva2 got %0d want 8", db_estado); end
    tick();
    checks++; if (db_estado !== 5'd4 || saidas !== 10'b00_0100_0000) begin errors++; $display("FAIL termina got st=%0d out=%b want st=4 out=0001000000", db_estado, saidas); end
    tick();
    checks++; if (db_estado !== 5'd4) begin errors++; $display("FAIL termina_hold got %0d want 4", db_estado); end
    fim_movimentacao = 1'b1; tick(); fim_movimentacao = 1'b0;
    checks++; if (db_estado !== 5'd7 || inicia_acao !== 2'b01) begin errors++; $display("FAIL dispatch0 got st=%0d ia=%b want st=7 ia=01", db_estado, inicia_acao); end
    tick(); carga0 = ciclo;
    checks++; if (db_estado !== 5'd5 || inicia_acao !== 2'b00 || acao_pronta !== 2'b10) begin errors++; $display("FAIL espera_acao got st=%0d ia=%b pr=%b want st=5 ia=00 pr=10", db_estado, inicia_acao, acao_pronta); end
    fim_acao = 2'b10; tick();
    checks++; if (db_estado !== 5'd5) begin errors++; $display("FAIL other_fim_ignored got %0d want 5", db_estado); end
    fim_acao = 2'b01; tick(); fim_acao = 2'b00;
    checks++; if (db_estado !== 5'd2) begin errors++; $display("FAIL fim_acao_exit got %0d want 2", db_estado); end
  endtask

  task automatic test_cooldown_block();
    int pulsos;
    pulsos = 0;
    acoes = 2'b01; ocorreu_jogada = 1'b1; tick(); ocorreu_jogada = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (inicia_acao !== 2'b00) pulsos++;
      tick();
    end
    checks++; if (db_estado !== 5'd2 || pulsos != 0) begin errors++; $display("FAIL blocked_move got st=%0d pulses=%0d want st=2 pulses=0", db_estado, pulsos); end
    jogada(2'b11);
    checks++; if (db_estado !== 5'd4) begin errors++; $display("FAIL alt_termina got %0d want 4", db_estado); end
    fim_movimentacao = 1'b1; tick(); fim_movimentacao = 1'b0;
    checks++; if (inicia_acao !== 2'b10) begin errors++; $display("FAIL dispatch1 got %b want 10", inicia_acao); end
    tick(); carga1 = ciclo;
    checks++; if (acao_pronta !== 2'b00) begin errors++; $display("FAIL both_cooling got %b want 00", acao_pronta); end
    fim_acao = 2'b10; tick(); fim_acao = 2'b00;
    checks++; if (db_estado !== 5'd2) begin errors++; $display("FAIL fim_acao1_exit got %0d want 2", db_estado); end
    while (ciclo - carga0 < INTERV - 1) tick();
    checks++; if (acao_pronta[0] !== 1'b0) begin errors++; $display("FAIL cooldown_last got %b want 0", acao_pronta[0]); end
    tick();
    // channel 0 expired; channel 1 was loaded 12 clocks later and is still cooling
    checks++; if (acao_pronta !== 2'b01) begin errors++; $display("FAIL cooldown_expire got %b want 01", acao_pronta); end
  endtask

  task automatic test_timeout();
    int pulsos, pos, k;
    jogada(2'b01);
    checks++; if (db_estado !== 5'd4) begin errors++; $display("FAIL tmo_termina got %0d want 4", db_estado); end
    fim_movimentacao = 1'b1; tick(); fim_movimentacao = 1'b0;
    tick();
    pulsos = 0; pos = -1; k = 0;
    while (db_estado == 5'd5 && k < TMO + 16) begin
      if (erro_timeout === 1'b1) begin pulsos++; pos = k; end
      tick(); k++;
    end
    checks++; if (pulsos != 1 || pos != TMO - 1) begin errors++; $display("FAIL timeout_pulse got n=%0d at=%0d want n=1 at=%0d", pulsos, pos, TMO - 1); end
    checks++; if (k != TMO || db_estado !== 5'd2 || erro_timeout !== 1'b0) begin errors++; $display("FAIL timeout_exit got k=%0d st=%0d err=%b want k=%0d st=2 err=0", k, db_estado, erro_timeout, TMO); end
  endtask

  task automatic test_vidas();
    jogada(2'b10);
    checks++; if (db_estado !== 5'd4) begin errors++; $display("FAIL vidas_termina got %0d want 4", db_estado); end
    vidas = 1'b0; fim_movimentacao = 1'b1; tick(); fim_movimentacao = 1'b0; vidas = 1'b1;
    checks++; if (db_estado !== 5'd6 || saidas !== 10'b01_0010_1000) begin errors++; $display("FAIL fim_jogo got st=%0d out=%b want st=6 out=0100101000", db_estado, saidas); end
    tick();
    checks++; if (db_estado !== 5'd6) begin errors++; $display("FAIL fim_jogo_hold got %0d want 6", db_estado); end
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    checks++; if (db_estado !== 5'd1) begin errors++; $display("FAIL restart got %0d want 1", db_estado); end
    tick();
    checks++; if (db_estado !== 5'd2 || acao_pronta !== 2'b11) begin errors++; $display("FAIL restart_clear got st=%0d pr=%b want st=2 pr=11", db_estado, acao_pronta); end
    vidas = 1'b0; ocorreu_jogada = 1'b1; tick(); ocorreu_jogada = 1'b0; vidas = 1'b1;
    checks++; if (db_estado !== 5'd6) begin errors++; $display("FAIL vidas_precedence got %0d want 6", db_estado); end
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
  endtask

  task automatic test_async_reset();
    jogada(2'b01);
    fim_movimentacao = 1'b1; tick(); fim_movimentacao = 1'b0; tick();
    checks++; if (db_estado !== 5'd5 || acao_pronta !== 2'b10) begin errors++; $display("FAIL pre_reset got st=%0d pr=%b want st=5 pr=10", db_estado, acao_pronta); end
    #2 reset = 1'b1;
    #1;
    checks++; if (db_estado !== 5'd0 || saidas !== 10'b0 || acao_pronta !== 2'b11) begin errors++; $display("FAIL async_reset got st=%0d out=%b pr=%b want st=0 out=0 pr=11", db_estado, saidas, acao_pronta); end
    tick(); reset = 1'b0;
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    checks++; if (db_estado !== 5'd2) begin errors++; $display("FAIL post_reset got %0d want 2", db_estado); end
  endtask

`ifdef UC_PAUSA_EN
  task automatic test_pausa();
    jogada(2'b01);
    fim_movimentacao = 1'b1; fim_acao = 2'b01; tick(); fim_movimentacao = 1'b0;
    tick(); carga0 = ciclo; tick(); fim_acao = 2'b00;
    pausa = 1'b1; ocorreu_jogada = 1'b1; tick(); ocorreu_jogada = 1'b0;
    checks++; if (db_estado !== 5'd12 || saidas !== 10'b0) begin errors++; $display("FAIL pausa_enter got st=%0d out=%b want st=12 out=0", db_estado, saidas); end
    repeat (10) tick();
    checks++; if (db_estado !== 5'd12 || acao_pronta[0] !== 1'b0) begin errors++; $display("FAIL pausa_hold got st=%0d pr=%b want st=12 pr0=0", db_estado, acao_pronta); end
    pausa = 1'b0; tick();
    checks++; if (db_estado !== 5'd2) begin errors++; $display("FAIL pausa_exit got %0d want 2", db_estado); end
    // 11 frozen edges: count reaches zero 51 clocks after the load instead of 40
    while (ciclo - carga0 < INTERV + 11 - 1) tick();
    checks++; if (acao_pronta[0] !== 1'b0) begin errors++; $display("FAIL pausa_remaining got %b want 0", acao_pronta[0]); end
    tick();
    checks++; if (acao_pronta[0] !== 1'b1) begin errors++; $display("FAIL pausa_expire got %b want 1", acao_pronta[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_dispatch();
    test_cooldown_block();
    test_timeout();
    test_vidas();
    test_async_reset();
`ifdef UC_PAUSA_EN
    test_pausa();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
